// File: rtl/if_fetch_resp_if.sv
// Fetch-response bundle: IF request, instruction-memory port and ID output.
// slave = the fetch responder, master = the surrounding IF/memory/ID side.
interface if_fetch_resp_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_pc;
  logic              req_ready;
  logic              flush;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_misal;

  modport slave (
    input  req_valid, req_pc, flush, mem_req_ready, mem_resp_valid,
           mem_resp_data, inst_ready,
    output req_ready, mem_req_valid, mem_req_addr, inst_valid, inst,
           inst_pc, inst_misal
  );

  modport master (
    output req_valid, req_pc, flush, mem_req_ready, mem_resp_valid,
           mem_resp_data, inst_ready,
    input  req_ready, mem_req_valid, mem_req_addr, inst_valid, inst,
           inst_pc, inst_misal
  );
endinterface

// File: rtl/if_fetch_resp.sv
// Fetch responder: single-outstanding I-memory read per accepted PC, selects
// the 32-bit half of the returned word and holds it for ID until consumed.
module if_fetch_resp #(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  if_fetch_resp_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t            state;
  logic              kill;
  logic [ADDR_W-1:0] pc_q;
  logic              fire;
  logic              misal;

  always_comb begin
    bus.req_ready = ~bus.flush & ~kill &
                    ((state == IDLE) | ((state == HOLD) & bus.inst_ready));
    fire  = bus.req_valid & bus.req_ready;
    misal = |bus.req_pc[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      kill              <= 1'b0;
      pc_q              <= '0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.inst_valid    <= 1'b0;
      bus.inst          <= '0;
      bus.inst_pc       <= '0;
      bus.inst_misal    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        REQ: begin
          // A flushed request is still completed so the bus sees no withdrawal.
          if (bus.flush) kill <= 1'b1;
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            if (kill | bus.flush) begin
              kill  <= 1'b0;
              state <= IDLE;
            end else begin
              bus.inst       <= pc_q[2] ? bus.mem_resp_data[63:32]
                                        : bus.mem_resp_data[31:0];
              bus.inst_pc    <= pc_q;
              bus.inst_misal <= 1'b0;
              bus.inst_valid <= 1'b1;
              state          <= HOLD;
            end
          end else if (bus.flush) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.flush | bus.inst_ready) begin
            bus.inst_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Acceptance overrides the per-state defaults above (IDLE or drained HOLD).
      if (fire) begin
        if (misal) begin
          bus.inst       <= NOP_INST;
          bus.inst_pc    <= bus.req_pc;
          bus.inst_misal <= 1'b1;
          bus.inst_valid <= 1'b1;
          state          <= HOLD;
        end else begin
          pc_q              <= bus.req_pc;
          bus.mem_req_valid <= 1'b1;
          bus.mem_req_addr  <= {bus.req_pc[ADDR_W-1:3], 3'b000};
          state             <= REQ;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_resp.sv
// Directed bench for if_fetch_resp with a latency-configurable memory responder.
module tb_if_fetch_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_resp_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  if_fetch_resp #(.ADDR_W(64), .DATA_W(64), .NOP_INST(32'h00000013)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder: response mem_lat cycles after the accepting edge.
  int          mem_lat     = 1;
  logic [63:0] mem_word    = '0;
  bit          use_pattern = 1'b0;

  initial begin
    logic [63:0] a;
    int          lat;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_req_valid && bus.mem_req_ready) begin
        a   = bus.mem_req_addr;
        lat = mem_lat;
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = use_pattern ? {a[31:0] + 32'h1000_0004, a[31:0] + 32'h1000_0000}
                                         : mem_word;
        @(posedge clk);
        #1 bus.mem_resp_valid = 1'b0;
      end
    end
  end

  int unsigned vcount = 0;
  logic [95:0] acc_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.inst_valid) begin
        vcount++;
        if (bus.inst_ready) acc_q.push_back({bus.inst_pc, bus.inst});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts just after a posedge; returns just after the accepting edge.
  task automatic fetch(input logic [63:0] pc);
    bit ok = 1'b0;
    bus.req_pc    = pc;
    bus.req_valid = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
    end
    if (!ok) check("fire_timeout", bus.req_ready, 1'b1);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_inst(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.inst_valid) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic consume();
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
  endtask

  initial begin
    int          cyc;
    int unsigned v0;
    int          waited;
    logic [63:0] pcs[3];

    bus.req_valid     = 1'b0;
    bus.req_pc        = '0;
    bus.flush         = 1'b0;
    bus.mem_req_ready = 1'b1;
    bus.inst_ready    = 1'b0;
    mem_word          = 64'h11111111_22222222;

    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
    check("rst_mem_req_addr",  bus.mem_req_addr, 64'h0);
    check("rst_inst_valid",    bus.inst_valid, 1'b0);
    check("rst_inst",          bus.inst, 32'h0);
    check("rst_inst_pc",       bus.inst_pc, 64'h0);
    check("rst_inst_misal",    bus.inst_misal, 1'b0);
    @(negedge clk) rst = 1'b0;
    step();

    // 1: aligned low half, 1-cycle memory
    fetch(64'h8000_0000);
    @(negedge clk);
    check("t1_mem_req_valid", bus.mem_req_valid, 1'b1);
    check("t1_mem_req_addr",  bus.mem_req_addr, 64'h8000_0000);
    wait_inst(cyc);
    check("t1_latency",    cyc + 1, 3);
    check("t1_inst",       bus.inst, 32'h22222222);
    check("t1_inst_pc",    bus.inst_pc, 64'h8000_0000);
    check("t1_inst_misal", bus.inst_misal, 1'b0);
    consume();
    @(negedge clk);
    check("t1_idle_valid", bus.inst_valid, 1'b0);
    check("t1_idle_ready", bus.req_ready, 1'b1);
    step();

    // 2: aligned high half
    fetch(64'h8000_0004);
    wait_inst(cyc);
    check("t2_latency", cyc, 3);
    check("t2_inst",    bus.inst, 32'h11111111);
    check("t2_inst_pc", bus.inst_pc, 64'h8000_0004);
    consume();

    // 3: misaligned PC yields NOP without memory traffic
    fetch(64'h8000_0002);
    @(negedge clk);
    check("t3_inst_valid",     bus.inst_valid, 1'b1);
    check("t3_mem_req_valid",  bus.mem_req_valid, 1'b0);
    check("t3_inst",           bus.inst, 32'h00000013);
    check("t3_inst_misal",     bus.inst_misal, 1'b1);
    check("t3_inst_pc",        bus.inst_pc, 64'h8000_0002);
    consume();

    // 4: flush in WAIT with 5-cycle memory, then fetch after drain
    mem_lat  = 5;
    mem_word = 64'hAAAAAAAA_BBBBBBBB;
    v0       = vcount;
    fetch(64'h8000_0008);
    @(negedge clk);
    check("t4_mem_req_valid", bus.mem_req_valid, 1'b1);
    @(negedge clk);
    bus.flush = 1'b1;
    step();
    bus.flush     = 1'b0;
    mem_lat       = 1;
    bus.req_pc    = 64'h8000_0010;
    bus.req_valid = 1'b1;
    waited = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        waited = k;
        break;
      end
    end
    check("t4_drain_cycles", waited, 5);
    step();
    bus.req_valid = 1'b0;
    check("t4_no_killed_inst", vcount, v0);
    wait_inst(cyc);
    check("t4_latency", cyc, 3);
    check("t4_inst",    bus.inst, 32'hBBBBBBBB);
    check("t4_inst_pc", bus.inst_pc, 64'h8000_0010);
    consume();

    // 5: hold stability, then back-to-back stream
    mem_word = 64'hCAFEF00D_DEADBEEF;
    fetch(64'h0);
    wait_inst(cyc);
    check("t5_inst", bus.inst, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_hold_valid", bus.inst_valid, 1'b1);
      check("t5_hold_inst",  bus.inst, 32'hDEADBEEF);
      check("t5_hold_pc",    bus.inst_pc, 64'h0);
    end
    step();
    use_pattern    = 1'b1;
    acc_q.delete();
    bus.inst_ready = 1'b1;
    pcs = '{64'h0, 64'h4, 64'h8};
    for (int i = 0; i < 3; i++) fetch(pcs[i]);
    for (int k = 0; k < 40 && acc_q.size() < 4; k++) step();
    bus.inst_ready = 1'b0;
    use_pattern    = 1'b0;
    check("t5_count", acc_q.size(), 4);
    if (acc_q.size() >= 4) begin
      check("t5_held",  acc_q[0], {64'h0, 32'hDEADBEEF});
      check("t5_b2b_0", acc_q[1], {64'h0, 32'h10000000});
      check("t5_b2b_1", acc_q[2], {64'h4, 32'h10000004});
      check("t5_b2b_2", acc_q[3], {64'h8, 32'h10000008});
    end

    // 6: memory back-pressure, then async reset mid-WAIT
    bus.mem_req_ready = 1'b0;
    mem_lat  = 5;
    mem_word = 64'h12345678_9ABCDEF0;
    fetch(64'h8000_0020);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_req_held_valid", bus.mem_req_valid, 1'b1);
      check("t6_req_held_addr",  bus.mem_req_addr, 64'h8000_0020);
    end
    step();
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_wait_req_valid", bus.mem_req_valid, 1'b0);
    check("t6_wait_ready",     bus.req_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t6_arst_mem_req_addr", bus.mem_req_addr, 64'h0);
    check("t6_arst_inst",         bus.inst, 32'h0);
    check("t6_arst_inst_pc",      bus.inst_pc, 64'h0);
    check("t6_arst_inst_valid",   bus.inst_valid, 1'b0);
    check("t6_arst_req_ready",    bus.req_ready, 1'b1);
    #1 rst = 1'b0;
    v0 = vcount;
    repeat (6) @(negedge clk);
    #1;
    check("t6_late_resp_ignored", vcount, v0);
    check("t6_idle_mem_req",      bus.mem_req_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
